// File: rtl/i2c_reg_slave_pkg.sv
// rtl/i2c_reg_slave_pkg.sv - shared FSM states, bus constants and helpers for the I2C register slave
package i2c_reg_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // General call (address 0) is never claimed, even if DEV_ADDR were set to it.
  function automatic logic addr_hit(input logic [7:0] frame, input logic [6:0] dev);
    return (frame[7:1] == dev) && (dev != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_reg_slave_pin_filter.sv
// rtl/i2c_reg_slave_pin_filter.sv - pad synchroniser plus run-length glitch filter with edge pulses
module i2c_reg_slave_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk_25,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sampled;

  assign sampled = sync[SYNC_STAGES-1];

  // Level flips only after FILT_LEN consecutive synchronised samples disagree with it.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sampled == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sampled;
        rise  <= sampled;
        fall  <= ~sampled;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C slave with pin conditioning, auto-incrementing pointer and register file
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h70,
  parameter int         N_REGS      = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3,
  parameter bit         PTR_WRAP    = 1'b1,
  parameter logic [7:0] RST_VAL     = 8'h00,
  parameter int         AW          = (N_REGS > 2) ? $clog2(N_REGS) : 1
) (
  input  logic                clk_25,
  input  logic                reset,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [N_REGS*8-1:0] regs_q,
  output logic                wr_stb,
  output logic [AW-1:0]       wr_addr,
  output logic                start_det,
  output logic                stop_det,
  output logic                busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_reg_slave_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_25 (clk_25),
    .reset  (reset),
    .pin    (scl_in),
    .level  (scl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_reg_slave_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_25 (clk_25),
    .reset  (reset),
    .pin    (sda_in),
    .level  (sda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          rw;
  logic          ack_pend;
  logic [7:0]    regs [N_REGS];
  logic [7:0]    frame;
  logic          ptr_ok;
  logic          start_cond;
  logic          stop_cond;

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;
  assign frame      = {shift[6:0], sda};
  assign ptr_ok     = ({1'b0, frame} < 9'(N_REGS));

  always_comb begin
    ptr_next = ptr + AW'(1);
    if (ptr == AW'(N_REGS - 1)) begin
      ptr_next = PTR_WRAP ? '0 : ptr;
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_regs_q
    assign regs_q[8*k +: 8] = regs[k];
  end

  // Bus conditions outrank any SCL edge in the same cycle, dropping partial bytes.
  // In read states the shifter holds the next bit to send in [7].
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < N_REGS; k++) regs[k] <= RST_VAL;
    end else begin
      wr_stb    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (stop_cond) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ack_pend <= 1'b0;
        stop_det <= 1'b1;
      end else if (start_cond) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        ack_pend  <= 1'b0;
        start_det <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= frame;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (addr_hit(frame, DEV_ADDR)) begin
                  state    <= ST_ADDR_ACK;
                  rw       <= frame[0];
                  busy     <= 1'b1;
                  ack_pend <= 1'b1;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= frame;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ST_WDATA) begin
                  regs[ptr] <= frame;
                  wr_stb    <= 1'b1;
                  wr_addr   <= ptr;
                  ptr       <= ptr_next;
                  state     <= ST_WDATA_ACK;
                  ack_pend  <= 1'b1;
                end else if (ptr_ok) begin
                  ptr      <= frame[AW-1:0];
                  state    <= ST_PTR_ACK;
                  ack_pend <= 1'b1;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (ack_pend) begin
                sda_oe   <= ~I2C_ACK;
                ack_pend <= 1'b0;
              end else if (state == ST_ADDR_ACK && rw) begin
                state   <= ST_RDATA;
                shift   <= {regs[ptr][6:0], 1'b0};
                sda_oe  <= ~regs[ptr][7];
                bit_cnt <= 4'd1;
              end else begin
                state   <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe   <= 1'b0;
                ack_pend <= 1'b0;
                state    <= ST_RDATA_ACK;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_NACK) begin
                state <= ST_WAIT_STOP;
              end else begin
                ptr      <= ptr_next;
                ack_pend <= 1'b1;
              end
            end else if (scl_fall && ack_pend) begin
              ack_pend <= 1'b0;
              state    <= ST_RDATA;
              shift    <= {regs[ptr][6:0], 1'b0};
              sda_oe   <= ~regs[ptr][7];
              bit_cnt  <= 4'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed bench driving an open-drain I2C master against i2c_reg_slave
`timescale 1ns/1ps
module tb_i2c_reg_slave;

  localparam int Q = 8;

  logic        clk_25 = 1'b0;
  logic        reset  = 1'b1;
  logic        scl_m  = 1'b1;
  logic        sda_m  = 1'b1;
  logic        sda_in;
  logic        sda_oe, wr_stb, start_det, stop_det, busy;
  logic [63:0] regs_q;
  logic [2:0]  wr_addr;
  logic [2:0]  last_wr_addr = 3'd0;

  int checks = 0, failures = 0;
  int wr_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  assign sda_in = sda_m & ~sda_oe;

  always #20 clk_25 = ~clk_25;

  i2c_reg_slave dut (
    .clk_25    (clk_25),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .regs_q    (regs_q),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  always @(negedge clk_25) begin
    if (wr_stb) begin
      wr_cnt++;
      last_wr_addr = wr_addr;
    end
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(3 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; clks(Q);
    scl_m = 1'b1; clks(2 * Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    b = sda_in; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
    write_bit(nack);
  endtask

  // 2-clock SCL pulse in the low phase of bit 6, 2-clock SDA dip while SCL is high in bit 4.
  task automatic write_byte_glitch(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (i == 6) begin
        clks(Q / 2); scl_m = 1'b1; clks(2); scl_m = 1'b0; clks(Q / 2);
      end else begin
        clks(Q);
      end
      scl_m = 1'b1;
      if (i == 4) begin
        clks(Q - 2); sda_m = ~b[i]; clks(2); sda_m = b[i]; clks(Q);
      end else begin
        clks(2 * Q);
      end
      scl_m = 1'b0; clks(Q);
    end
    read_bit(ack);
  endtask

  initial begin
    logic       ack;
    logic       bit_v;
    logic [7:0] rd;
    int         wr0, st0, sp0;

    clks(5);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_stb", wr_stb, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_start_det", start_det, 0);
    check_eq("rst_stop_det", stop_det, 0);
    check_eq("rst_regs", regs_q, 64'h0);
    reset = 1'b0;
    clks(10);

    // Write pointer 2 then A5, 5A.
    i2c_start();
    write_byte(8'hE0, ack); check_eq("t1_addr_ack", ack, 0);
    write_byte(8'h02, ack); check_eq("t1_ptr_ack", ack, 0);
    check_eq("t1_busy", busy, 1);
    write_byte(8'hA5, ack); check_eq("t1_d0_ack", ack, 0);
    write_byte(8'h5A, ack); check_eq("t1_d1_ack", ack, 0);
    i2c_stop();
    check_eq("t1_regs", regs_q, 64'h0000_0000_5AA5_0000);
    check_eq("t1_wr_cnt", wr_cnt, 2);
    check_eq("t1_last_wr_addr", last_wr_addr, 3);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_start_cnt", start_cnt, 1);
    check_eq("t1_stop_cnt", stop_cnt, 1);

    // Fill 6,7 and wrap into 0.
    i2c_start();
    write_byte(8'hE0, ack); write_byte(8'h06, ack);
    write_byte(8'h11, ack); write_byte(8'h22, ack);
    write_byte(8'h33, ack); check_eq("t2_wrap_ack", ack, 0);
    i2c_stop();
    check_eq("t2_regs", regs_q, 64'h2211_0000_5AA5_0033);

    // Set pointer 6, repeated START, read three bytes across the wrap.
    i2c_start();
    write_byte(8'hE0, ack); write_byte(8'h06, ack);
    i2c_rstart();
    write_byte(8'hE1, ack); check_eq("t2_rd_addr_ack", ack, 0);
    read_byte(rd, 1'b0); check_eq("t2_rd0", rd, 8'h11);
    read_byte(rd, 1'b0); check_eq("t2_rd1", rd, 8'h22);
    read_byte(rd, 1'b1); check_eq("t2_rd2", rd, 8'h33);
    i2c_stop();

    // Foreign address: never driven, never busy.
    wr0 = wr_cnt; sp0 = stop_cnt; oe_cnt = 0; busy_cnt = 0;
    i2c_start();
    write_byte(8'hC0, ack); check_eq("t3_addr_nack", ack, 1);
    write_byte(8'h00, ack); write_byte(8'h12, ack);
    i2c_stop();
    check_eq("t3_oe_cnt", oe_cnt, 0);
    check_eq("t3_busy_cnt", busy_cnt, 0);
    check_eq("t3_wr_cnt", wr_cnt - wr0, 0);
    check_eq("t3_stop_cnt", stop_cnt - sp0, 1);

    // Pointer out of range: NACK, data ignored, pointer kept at 0.
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'hE0, ack); check_eq("t4_addr_ack", ack, 0);
    write_byte(8'h09, ack); check_eq("t4_ptr_nack", ack, 1);
    write_byte(8'hFF, ack); check_eq("t4_data_nack", ack, 1);
    i2c_stop();
    check_eq("t4_regs", regs_q, 64'h2211_0000_5AA5_0033);
    check_eq("t4_wr_cnt", wr_cnt - wr0, 0);
    i2c_start();
    write_byte(8'hE1, ack);
    read_byte(rd, 1'b1); check_eq("t4_ptr_kept", rd, 8'h33);
    i2c_stop();

    // Glitched data byte into register 4.
    wr0 = wr_cnt; st0 = start_cnt; sp0 = stop_cnt;
    i2c_start();
    write_byte(8'hE0, ack); write_byte(8'h04, ack);
    write_byte_glitch(8'h3C, ack); check_eq("t5_glitch_ack", ack, 0);
    i2c_stop();
    check_eq("t5_regs", regs_q, 64'h2211_003C_5AA5_0033);
    check_eq("t5_wr_cnt", wr_cnt - wr0, 1);
    check_eq("t5_start_cnt", start_cnt - st0, 1);
    check_eq("t5_stop_cnt", stop_cnt - sp0, 1);

    // Reset in the middle of reading register 5 (all zeros, so SDA is being pulled).
    i2c_start();
    write_byte(8'hE1, ack); check_eq("t6_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) begin
      read_bit(bit_v);
      check_eq("t6_rd_bit", bit_v, 0);
    end
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    check_eq("t6_oe_before", sda_oe, 1);
    reset = 1'b1;
    #1;
    check_eq("t6_oe_reset", sda_oe, 0);
    check_eq("t6_regs_reset", regs_q, 64'h0);
    check_eq("t6_busy_reset", busy, 0);
    clks(4);
    reset = 1'b0;
    clks(20);
    i2c_start();
    write_byte(8'hE0, ack); check_eq("t6_post_addr_ack", ack, 0);
    write_byte(8'h01, ack); check_eq("t6_post_ptr_ack", ack, 0);
    write_byte(8'h77, ack); check_eq("t6_post_data_ack", ack, 0);
    i2c_stop();
    check_eq("t6_post_regs", regs_q, 64'h0000_0000_0000_7700);
    check_eq("t6_post_wr_addr", last_wr_addr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
